pe_mac_acc: RTL
===============

Name: pe_mac_acc

Overview:
Parametrised output-stationary systolic processing element for the TPU array; the next generation of the basic MAC PE. Forwards A/B operands to its east/south neighbours, multiply-accumulates valid operand pairs, and closes a dot product on a `last_in` marker. Completed results go into a one-entry result register drained via a valid/ready handshake, so the array can overlap the next tile's accumulation with readout.

Parameters:
DATA_W, 8, operand width of a_in/b_in.
ACC_W, 32, accumulator/result width; must be >= 2*DATA_W.
CNT_W, 8, width of the term counter reported with each result.
SIGNED, 0, 1 = two's-complement operands and accumulator, 0 = unsigned.
MUL_PIPE, 0, 0 = product added in the same cycle; 1 = one register stage on product/valid/last before the accumulator.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous reset, active-low.
a_in  input  DATA_W  west operand.
b_in  input  DATA_W  north operand.
valid_in  input  1  a_in/b_in qualify this cycle.
last_in  input  1  with valid_in: final term of the current dot product.
a_out  output  DATA_W  registered a_in to east neighbour.
b_out  output  DATA_W  registered b_in to south neighbour.
valid_out  output  1  registered valid_in.
last_out  output  1  registered last_in & valid_in.
result  output  ACC_W  completed dot product.
result_cnt  output  CNT_W  number of terms in result.
result_valid  output  1  result register full.
result_ready  input  1  consumer accepts result.
overrun  output  1  sticky: a result completed while result register full.
sat_seen  output  1  sticky: accumulator saturated (see Optional Feature).

Behaviour:
- Reset (rst_n low, async): a_out, b_out, result, result_cnt = 0; valid_out, last_out, result_valid, overrun, sat_seen = 0; accumulator and term counter = 0; MUL_PIPE stage cleared. State = EMPTY.
- Forwarding: 1-cycle latency regardless of MUL_PIPE. If valid_in, a_out/b_out <= a_in/b_in. Else a_out/b_out hold. valid_out <= valid_in; last_out <= valid_in & last_in. Never stalls; the PE has no input backpressure.
- Product: a_in*b_in at 2*DATA_W, sign- or zero-extended to ACC_W per SIGNED. Accumulate is ACC_W-wide and wraps modulo 2^ACC_W unless the optional feature is enabled.
- Accumulator FSM, driven by the accumulate-stage valid/last (input stage if MUL_PIPE=0, pipe register if 1):
  - EMPTY: valid & !last -> acc = prod, cnt = 1, go ACCUM. valid & last -> complete with prod, cnt 1, stay EMPTY.
  - ACCUM: valid & !last -> acc += prod, cnt += 1 (cnt saturates at all-ones). valid & last -> complete with acc+prod, cnt+1, acc = 0, cnt = 0, go EMPTY. !valid -> hold.
- Completion: if result_valid=0, or result_valid=1 & result_ready=1 the same cycle, then result/result_cnt load and result_valid = 1 next cycle. Otherwise the new result is dropped, overrun set (sticky until reset), and the register keeps the old value.
- Drain: result_valid & result_ready & no completion -> result_valid <= 0; result/result_cnt hold their last value.
- Latency: last term presented at cycle t -> result_valid at t+1 (MUL_PIPE=0) or t+2 (MUL_PIPE=1).
- Reset mid-accumulation discards the partial sum; no result is emitted.

Optional Feature:
Macro PE_ACC_SAT_EN.
- Defined: accumulate clamps to the ACC_W range (signed: -2^(ACC_W-1)..2^(ACC_W-1)-1; unsigned: 0..2^ACC_W-1) and sets sat_seen sticky on any clamp.
- Undefined: wrap-around arithmetic; sat_seen tied 0.

Test Plan:
1. DATA_W=8, unsigned, MUL_PIPE=0: pairs (3,4),(5,6),(2,10,last) consecutive, result_ready=1 -> result=62, result_cnt=3, result_valid one cycle after last; valid_out/a_out track inputs with 1-cycle delay.
2. SIGNED=1: (-3,4),(127,-128,last) -> result=-16268 sign-correct at ACC_W; a_out/b_out hold during valid_in=0 gaps with accumulator unchanged.
3. Backpressure: result_ready=0, two dot products complete (7 then 9, each single last term 7*1, 9*1) -> result stays 7, overrun=1; raise ready -> result_valid drops next cycle.
4. Simultaneous drain and completion: result_valid=1, ready=1 in the cycle a new result completes -> new value loaded, result_valid stays 1, overrun stays 0.
5. MUL_PIPE=1: same stimulus as test 1 -> result=62 at last+2; forwarding latency still 1.
6. PE_ACC_SAT_EN, ACC_W=16, unsigned: 2 terms of 255*255 -> result=65535, sat_seen=1; macro undefined -> 64514 (130050 mod 65536), sat_seen=0. Assert rst_n low mid-sum -> all outputs 0 immediately, no result emitted.

Source files
------------

// File: rtl/pe_mac_acc.sv
// ============================================================================
// Module   : pe_mac_acc
// Brief    : Output-stationary systolic MAC PE with operand forwarding, a
//            one-entry result register drained by valid/ready, and optional
//            saturating accumulation (macro PE_ACC_SAT_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_mac_acc #(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 32,
    parameter int CNT_W    = 8,
    parameter int SIGNED   = 0,
    parameter int MUL_PIPE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              valid_in,
    input  logic              last_in,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic              valid_out,
    output logic              last_out,
    output logic [ACC_W-1:0]  result,
    output logic [CNT_W-1:0]  result_cnt,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              overrun,
    output logic              sat_seen
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    state_t              r_state;
    logic [ACC_W-1:0]    r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_a_out;
    logic [DATA_W-1:0]   r_b_out;
    logic                r_valid_out;
    logic                r_last_out;
    logic [ACC_W-1:0]    r_result;
    logic [CNT_W-1:0]    r_result_cnt;
    logic                r_result_valid;
    logic                r_overrun;

    logic [2*DATA_W-1:0] w_prod_raw;
    logic [ACC_W-1:0]    w_prod;
    logic [ACC_W-1:0]    w_acc_prod;
    logic                w_acc_valid;
    logic                w_acc_last;
    logic [ACC_W-1:0]    w_base;
    logic [ACC_W-1:0]    w_sum;
    logic [CNT_W-1:0]    w_cnt_next;
    logic                w_complete;
    logic                w_accept;

    // Operands are extended to full product width before multiplying so the
    // product width is explicit and no truncation surprises occur.
    generate
        if (SIGNED != 0) begin : g_signed
            assign w_prod_raw = $signed({{DATA_W{a_in[DATA_W-1]}}, a_in})
                              * $signed({{DATA_W{b_in[DATA_W-1]}}, b_in});
            assign w_prod     = ACC_W'($signed(w_prod_raw));
        end else begin : g_unsigned
            assign w_prod_raw = {{DATA_W{1'b0}}, a_in} * {{DATA_W{1'b0}}, b_in};
            assign w_prod     = ACC_W'(w_prod_raw);
        end
    endgenerate

    generate
        if (MUL_PIPE != 0) begin : g_mul_pipe
            logic [ACC_W-1:0] r_pipe_prod;
            logic             r_pipe_valid;
            logic             r_pipe_last;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pipe_prod  <= '0;
                    r_pipe_valid <= 1'b0;
                    r_pipe_last  <= 1'b0;
                end else begin
                    r_pipe_valid <= valid_in;
                    r_pipe_last  <= valid_in & last_in;
                    if (valid_in) begin
                        r_pipe_prod <= w_prod;
                    end
                end
            end

            assign w_acc_prod  = r_pipe_prod;
            assign w_acc_valid = r_pipe_valid;
            assign w_acc_last  = r_pipe_last;
        end else begin : g_no_pipe
            assign w_acc_prod  = w_prod;
            assign w_acc_valid = valid_in;
            assign w_acc_last  = last_in;
        end
    endgenerate

    // A fresh dot product starts from zero, so EMPTY adds the product to 0.
    assign w_base     = (r_state == ST_ACCUM) ? r_acc : '0;
    assign w_cnt_next = (r_state == ST_EMPTY) ? CNT_W'(1)
                      : ((&r_cnt) ? r_cnt : r_cnt + CNT_W'(1));
    assign w_complete = w_acc_valid & w_acc_last;
    assign w_accept   = ~r_result_valid | result_ready;

`ifdef PE_ACC_SAT_EN
    localparam logic [ACC_W-1:0] c_smax = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] c_smin = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0] w_wide;
    logic           w_sat;
    logic           r_sat_seen;

    assign w_wide = {1'b0, w_base} + {1'b0, w_acc_prod};

    always_comb begin
        w_sum = w_wide[ACC_W-1:0];
        w_sat = 1'b0;
        if (SIGNED != 0) begin
            // Signed overflow: like-signed operands giving an opposite-signed sum.
            if ((w_base[ACC_W-1] == w_acc_prod[ACC_W-1]) &&
                (w_wide[ACC_W-1] != w_base[ACC_W-1])) begin
                w_sat = 1'b1;
                w_sum = w_base[ACC_W-1] ? c_smin : c_smax;
            end
        end else if (w_wide[ACC_W]) begin
            w_sat = 1'b1;
            w_sum = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_seen <= 1'b0;
        end else if (w_acc_valid && w_sat) begin
            r_sat_seen <= 1'b1;
        end
    end

    assign sat_seen = r_sat_seen;
`else
    assign w_sum    = w_base + w_acc_prod;
    assign sat_seen = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_EMPTY;
            r_acc          <= '0;
            r_cnt          <= '0;
            r_a_out        <= '0;
            r_b_out        <= '0;
            r_valid_out    <= 1'b0;
            r_last_out     <= 1'b0;
            r_result       <= '0;
            r_result_cnt   <= '0;
            r_result_valid <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            if (valid_in) begin
                r_a_out <= a_in;
                r_b_out <= b_in;
            end
            r_valid_out <= valid_in;
            r_last_out  <= valid_in & last_in;

            if (w_acc_valid) begin
                if (w_acc_last) begin
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    r_state <= ST_EMPTY;
                end else begin
                    r_acc   <= w_sum;
                    r_cnt   <= w_cnt_next;
                    r_state <= ST_ACCUM;
                end
            end

            if (w_complete) begin
                if (w_accept) begin
                    r_result       <= w_sum;
                    r_result_cnt   <= w_cnt_next;
                    r_result_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_result_valid && result_ready) begin
                r_result_valid <= 1'b0;
            end
        end
    end

    assign a_out        = r_a_out;
    assign b_out        = r_b_out;
    assign valid_out    = r_valid_out;
    assign last_out     = r_last_out;
    assign result       = r_result;
    assign result_cnt   = r_result_cnt;
    assign result_valid = r_result_valid;
    assign overrun      = r_overrun;

endmodule

`default_nettype wire
